// File: rtl/gpu_display_ctrl_if.sv
// Display controller bus: layer renderer request/return, video out, register port, irq.
// Ports: master = display controller (drives coords, video, rdata, irq);
//        slave  = renderers and host (drive layer returns and register accesses).
interface gpu_display_ctrl_if #(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_W    = 6
);
    logic [7:0]                    win_x;
    logic [7:0]                    win_y;
    logic                          in_vblank;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]         layer_valid;
    logic [COLOR_W-1:0]            rgb;
    logic                          hsync;
    logic                          vsync;
    logic                          controller_start_fetch;
    logic [1:0]                    reg_addr;
    logic [7:0]                    reg_wdata;
    logic                          reg_we;
    logic                          reg_sel;
    logic [7:0]                    reg_rdata;
    logic                          irq;

    modport master (
        output win_x, win_y, in_vblank, rgb, hsync, vsync, controller_start_fetch,
        output reg_rdata, irq,
        input  layer_rgb, layer_valid, reg_addr, reg_wdata, reg_we, reg_sel
    );

    modport slave (
        input  win_x, win_y, in_vblank, rgb, hsync, vsync, controller_start_fetch,
        input  reg_rdata, irq,
        output layer_rgb, layer_valid, reg_addr, reg_wdata, reg_we, reg_sel
    );
endinterface

// File: rtl/gpu_display_ctrl.sv
// Raster timing, N-layer priority compositor, and STATUS/IRQ_EN/LINE_CMP/LAYER_EN registers.
// Latency: counters -> rgb/hsync/vsync is LAYER_LATENCY+1 clks; reg_rdata combinational; irq registered.
// Ports: clk, rst (sync, active-high); bus (master): window coords out, layer returns in, video out, reg port.
module gpu_display_ctrl #(
    parameter int H_VISIBLE     = 320,
    parameter int H_FRONT       = 8,
    parameter int H_SYNC        = 48,
    parameter int H_BACK        = 24,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int WIN_X0        = 32,
    parameter int WIN_W         = 256,
    parameter int WIN_H         = 240,
    parameter int Y_SHIFT       = 1,
    parameter int NUM_LAYERS    = 2,
    parameter int COLOR_W       = 6,
    parameter int LAYER_LATENCY = 1,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0,
    parameter int FETCH_LEN     = 50
) (
    input  logic            clk,
    input  logic            rst,
    gpu_display_ctrl_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    // Selects the v_count bits dropped by the vertical scaling; a line match
    // only fires on the first physical line of each scaled line.
    localparam logic [31:0] Y_MASK = (32'd1 << Y_SHIFT) - 32'd1;

    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    logic [31:0]    h32;
    logic [31:0]    v32;
    logic [31:0]    win_y32;
    logic [7:0]     win_y8;
    logic           in_vblank;
    logic           drawing;
    logic           hs_raw;
    logic           vs_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_W'(H_TOTAL - 1)) begin
            h_count <= '0;
            v_count <= (v_count == V_W'(V_TOTAL - 1)) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    assign h32       = 32'(h_count);
    assign v32       = 32'(v_count);
    assign win_y32   = v32 >> Y_SHIFT;
    assign win_y8    = 8'(win_y32);
    assign in_vblank = (v32 >= V_VISIBLE);
    assign drawing   = (h32 < H_VISIBLE) && (v32 < V_VISIBLE) &&
                       (h32 >= WIN_X0) && (h32 < WIN_X0 + WIN_W) && (win_y32 < WIN_H);
    assign hs_raw    = !((h32 >= H_VISIBLE + H_FRONT) && (h32 < H_VISIBLE + H_FRONT + H_SYNC));
    assign vs_raw    = !((v32 >= V_VISIBLE + V_FRONT) && (v32 < V_VISIBLE + V_FRONT + V_SYNC));

    assign bus.win_x                  = 8'(h32 - WIN_X0);
    assign bus.win_y                  = win_y8;
    assign bus.in_vblank              = in_vblank;
    assign bus.controller_start_fetch = (v32 == 0) && (h32 < FETCH_LEN);

    // Delay drawing/syncs to line up with the layer renderers' returns.
    logic draw_d;
    logic hs_d;
    logic vs_d;

    generate
        if (LAYER_LATENCY == 0) begin : g_nodly
            assign draw_d = drawing;
            assign hs_d   = hs_raw;
            assign vs_d   = vs_raw;
        end else begin : g_dly
            logic [LAYER_LATENCY-1:0] draw_sr;
            logic [LAYER_LATENCY-1:0] hs_sr;
            logic [LAYER_LATENCY-1:0] vs_sr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    draw_sr <= '0;
                    hs_sr   <= '1;
                    vs_sr   <= '1;
                end else begin
                    draw_sr <= LAYER_LATENCY'({draw_sr, drawing});
                    hs_sr   <= LAYER_LATENCY'({hs_sr, hs_raw});
                    vs_sr   <= LAYER_LATENCY'({vs_sr, vs_raw});
                end
            end
            assign draw_d = draw_sr[LAYER_LATENCY-1];
            assign hs_d   = hs_sr[LAYER_LATENCY-1];
            assign vs_d   = vs_sr[LAYER_LATENCY-1];
        end
    endgenerate

    logic [NUM_LAYERS-1:0] layer_en;
    logic [COLOR_W-1:0]    pix;
    logic [COLOR_W-1:0]    rgb_q;
    logic                  hsync_q;
    logic                  vsync_q;

    // Walk from lowest priority up so the lowest enabled+valid index wins.
    always_comb begin
        pix = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_valid[i] && layer_en[i]) begin
                pix = bus.layer_rgb[i*COLOR_W +: COLOR_W];
            end
        end
        if (!draw_d) begin
            pix = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= pix;
            hsync_q <= hs_d;
            vsync_q <= vs_d;
        end
    end

    assign bus.rgb   = rgb_q;
    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;

    // Registers and interrupt sources.
    logic [3:1] flags;
    logic [3:1] irq_en;
    logic [7:0] line_cmp;
    logic       started;
    logic       irq_q;
    logic       wr;
    logic [3:1] ev;
    logic [3:1] clr;
    logic [7:0] en8;

    assign wr = bus.reg_we && bus.reg_sel;

    // 'started' masks the (0,0) position seen on the first cycle out of reset,
    // so the first vblank_end belongs to the next real frame wrap.
    always_comb begin
        ev    = '0;
        ev[1] = started && (h32 == 0) && (v32 == V_VISIBLE);
        ev[2] = started && (h32 == 0) && (v32 == 0);
        ev[3] = started && (h32 == 0) && (v32 < V_VISIBLE) &&
                ((v32 & Y_MASK) == 0) && (win_y8 == line_cmp);
        clr   = (wr && bus.reg_addr == 2'd0) ? bus.reg_wdata[3:1] : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags    <= '0;
            irq_en   <= '0;
            line_cmp <= '0;
            layer_en <= '1;
            started  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            started <= 1'b1;
            flags   <= ev | (flags & ~clr);
            irq_q   <= |(flags & irq_en);
            if (wr) begin
                case (bus.reg_addr)
                    2'd1:    irq_en   <= bus.reg_wdata[3:1];
                    2'd2:    line_cmp <= bus.reg_wdata;
                    2'd3:    layer_en <= bus.reg_wdata[NUM_LAYERS-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        en8                 = '0;
        en8[NUM_LAYERS-1:0] = layer_en;
        bus.reg_rdata       = '0;
        case (bus.reg_addr)
            2'd0:    bus.reg_rdata = {4'b0000, flags, in_vblank};
            2'd1:    bus.reg_rdata = {4'b0000, irq_en, 1'b0};
            2'd2:    bus.reg_rdata = line_cmp;
            default: bus.reg_rdata = en8;
        endcase
    end

    assign bus.irq = irq_q;
endmodule

// File: tb/tb_gpu_display_ctrl.sv
// Directed bench for gpu_display_ctrl with a shortened vertical frame (60 lines)
// and a non-zero background colour so every output path is observable.
module tb_gpu_display_ctrl;
    localparam int H_TOT = 400;
    localparam int V_TOT = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   th = 0;
    int   tv = 0;

    gpu_display_ctrl_if #(.NUM_LAYERS(2), .COLOR_W(6)) bus ();

    gpu_display_ctrl #(
        .V_VISIBLE(50), .V_FRONT(4), .V_SYNC(2), .V_BACK(4), .BG_COLOR(6'h2A)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference raster position: the counter value the DUT should hold after each edge.
    always @(posedge clk) begin
        if (rst) begin
            th <= 0;
            tv <= 0;
        end else if (th == H_TOT - 1) begin
            th <= 0;
            tv <= (tv == V_TOT - 1) ? 0 : tv + 1;
        end else begin
            th <= th + 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(th == h && tv == v) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (!(th == h && tv == v)) begin
            n_fail++;
            $display("FAIL wait_pos: at (%0d,%0d) required (%0d,%0d)", th, tv, h, v);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic sel);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_we    = 1'b1;
        bus.reg_sel   = sel;
        @(negedge clk);
        bus.reg_we    = 1'b0;
        bus.reg_sel   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.reg_addr = a;
        #1;
        d = bus.reg_rdata;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        step(3);
        n_tests++; if (bus.win_x !== 8'd224) begin n_fail++; $display("FAIL rst_win_x: got %0d required 224", bus.win_x); end
        n_tests++; if (bus.win_y !== 8'd0) begin n_fail++; $display("FAIL rst_win_y: got %0d required 0", bus.win_y); end
        n_tests++; if (bus.rgb !== 6'h00) begin n_fail++; $display("FAIL rst_rgb: got %h required 00", bus.rgb); end
        n_tests++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin n_fail++; $display("FAIL rst_syncs: got h%b v%b required 1 1", bus.hsync, bus.vsync); end
        n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b required 0", bus.irq); end
        n_tests++; if (bus.controller_start_fetch !== 1'b1) begin n_fail++; $display("FAIL rst_fetch: got %b required 1", bus.controller_start_fetch); end
        rd(2'd0, d); n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_status: got %h required 00", d); end
        rd(2'd1, d); n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_irq_en: got %h required 00", d); end
        rd(2'd2, d); n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_line_cmp: got %h required 00", d); end
        rd(2'd3, d); n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL rst_layer_en: got %h required 03", d); end
        @(negedge clk);
        rst = 1'b0;
        step(2);
        rd(2'd0, d); n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL first_vblank_end_suppressed: got %h required 00", d); end
    endtask

    task automatic test_registers;
        logic [7:0] d;
        @(negedge clk);
        wr(2'd1, 8'hFF, 1'b1); rd(2'd1, d);
        n_tests++; if (d !== 8'h0E) begin n_fail++; $display("FAIL irq_en_mask: got %h required 0e", d); end
        wr(2'd2, 8'hA5, 1'b1); rd(2'd2, d);
        n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL line_cmp_rw: got %h required a5", d); end
        wr(2'd2, 8'h11, 1'b0); rd(2'd2, d);
        n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL write_needs_sel: got %h required a5", d); end
        wr(2'd3, 8'hFF, 1'b1); rd(2'd3, d);
        n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL layer_en_mask: got %h required 03", d); end
        wr(2'd1, 8'h00, 1'b1);
        wr(2'd2, 8'd20, 1'b1);
        wr(2'd3, 8'h03, 1'b1);
    endtask

    task automatic test_frame;
        int  n, len, hs_cnt, vs_cnt, f_cnt, hs_first, vs_fh, vs_fv;
        logic prev;
        prev = bus.controller_start_fetch;
        n = 0;
        while (n < 30000) begin
            @(negedge clk); n++;
            if (prev && !bus.controller_start_fetch) break;
            prev = bus.controller_start_fetch;
        end
        len = 0; hs_cnt = 0; vs_cnt = 0; f_cnt = 0;
        hs_first = -1; vs_fh = -1; vs_fv = -1;
        prev = 1'b0;
        while (len < 30000) begin
            @(negedge clk); len++;
            if (tv == 0 && !bus.hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = th;
            end
            if (!bus.vsync) begin
                vs_cnt++;
                if (vs_fh < 0) begin vs_fh = th; vs_fv = tv; end
            end
            if (bus.controller_start_fetch) f_cnt++;
            if (prev && !bus.controller_start_fetch) break;
            prev = bus.controller_start_fetch;
        end
        n_tests++; if (len !== 24000) begin n_fail++; $display("FAIL frame_len: got %0d required 24000", len); end
        n_tests++; if (hs_cnt !== 48) begin n_fail++; $display("FAIL hsync_width: got %0d required 48", hs_cnt); end
        n_tests++; if (hs_first !== 330) begin n_fail++; $display("FAIL hsync_start: got %0d required 330", hs_first); end
        n_tests++; if (vs_cnt !== 800) begin n_fail++; $display("FAIL vsync_width: got %0d required 800", vs_cnt); end
        n_tests++; if (vs_fh !== 2 || vs_fv !== 54) begin n_fail++; $display("FAIL vsync_start: got (%0d,%0d) required (2,54)", vs_fh, vs_fv); end
        n_tests++; if (f_cnt !== 50) begin n_fail++; $display("FAIL fetch_width: got %0d required 50", f_cnt); end
    endtask

    task automatic test_layers;
        wait_pos(102, 5);
        n_tests++; if (bus.win_x !== 8'd70 || bus.win_y !== 8'd2) begin n_fail++; $display("FAIL win_coords: got (%0d,%0d) required (70,2)", bus.win_x, bus.win_y); end
        n_tests++; if (bus.rgb !== 6'h3F) begin n_fail++; $display("FAIL prio_layer0: got %h required 3f", bus.rgb); end
        wr(2'd3, 8'h02, 1'b1);
        wait_pos(150, 5);
        n_tests++; if (bus.rgb !== 6'h15) begin n_fail++; $display("FAIL layer_en_10: got %h required 15", bus.rgb); end
        wr(2'd3, 8'h03, 1'b1);
        bus.layer_valid = 2'b10;
        wait_pos(200, 5);
        n_tests++; if (bus.rgb !== 6'h15) begin n_fail++; $display("FAIL only_layer1_valid: got %h required 15", bus.rgb); end
        bus.layer_valid = 2'b00;
        wait_pos(220, 5);
        n_tests++; if (bus.rgb !== 6'h2A) begin n_fail++; $display("FAIL bg_none_valid: got %h required 2a", bus.rgb); end
        bus.layer_valid = 2'b11;
        wr(2'd3, 8'h00, 1'b1);
        wait_pos(250, 5);
        n_tests++; if (bus.rgb !== 6'h2A) begin n_fail++; $display("FAIL bg_none_enabled: got %h required 2a", bus.rgb); end
        wr(2'd3, 8'h03, 1'b1);
        wait_pos(300, 5);
        n_tests++; if (bus.rgb !== 6'h00) begin n_fail++; $display("FAIL outside_window: got %h required 00", bus.rgb); end
    endtask

    task automatic test_window_edge;
        wait_pos(33, 6);
        n_tests++; if (bus.rgb !== 6'h00) begin n_fail++; $display("FAIL left_edge_h31: got %h required 00", bus.rgb); end
        step(1);
        n_tests++; if (bus.rgb !== 6'h3F) begin n_fail++; $display("FAIL left_edge_h32: got %h required 3f", bus.rgb); end
        wait_pos(289, 6);
        n_tests++; if (bus.rgb !== 6'h3F) begin n_fail++; $display("FAIL right_edge_h287: got %h required 3f", bus.rgb); end
        step(1);
        n_tests++; if (bus.rgb !== 6'h00) begin n_fail++; $display("FAIL right_edge_h288: got %h required 00", bus.rgb); end
    endtask

    task automatic test_line_match;
        logic [7:0] d;
        wait_pos(10, 30);
        wr(2'd0, 8'h0E, 1'b1);
        rd(2'd0, d); n_tests++; if ((d & 8'h08) !== 8'h00) begin n_fail++; $display("FAIL lm_cleared: got %h required bit3 0", d); end
        wait_pos(1, 40);
        rd(2'd0, d); n_tests++; if ((d & 8'h08) !== 8'h08) begin n_fail++; $display("FAIL lm_fires_v40: got %h required bit3 1", d); end
        wr(2'd0, 8'h08, 1'b1);
        wait_pos(1, 41);
        rd(2'd0, d); n_tests++; if ((d & 8'h08) !== 8'h00) begin n_fail++; $display("FAIL lm_not_v41: got %h required bit3 0", d); end
        wr(2'd2, 8'd21, 1'b1);
        wait_pos(0, 42);
        wr(2'd0, 8'h08, 1'b1);
        rd(2'd0, d); n_tests++; if ((d & 8'h08) !== 8'h08) begin n_fail++; $display("FAIL lm_set_wins: got %h required bit3 1", d); end
        wr(2'd0, 8'h08, 1'b1);
        rd(2'd0, d); n_tests++; if ((d & 8'h08) !== 8'h00) begin n_fail++; $display("FAIL lm_w1c: got %h required bit3 0", d); end
    endtask

    task automatic test_irq;
        logic [7:0] d;
        wait_pos(10, 45);
        wr(2'd1, 8'h02, 1'b1);
        wr(2'd0, 8'h0E, 1'b1);
        wait_pos(0, 50);
        rd(2'd0, d); n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL vb_before_event: got %h required 01", d); end
        step(1);
        rd(2'd0, d); n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL vb_start_flag: got %h required 03", d); end
        n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_not_yet: got %b required 0", bus.irq); end
        step(1);
        n_tests++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_asserts: got %b required 1", bus.irq); end
        wr(2'd0, 8'h02, 1'b1);
        rd(2'd0, d); n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL vb_clear_keeps_bit0: got %h required 01", d); end
        step(1);
        n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_deasserts: got %b required 0", bus.irq); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] d;
        wait_pos(340, 54);
        n_tests++; if (bus.hsync !== 1'b0 || bus.vsync !== 1'b0) begin n_fail++; $display("FAIL syncs_low_pre_rst: got h%b v%b required 0 0", bus.hsync, bus.vsync); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin n_fail++; $display("FAIL syncs_after_rst: got h%b v%b required 1 1", bus.hsync, bus.vsync); end
        n_tests++; if (bus.win_x !== 8'd224 || bus.win_y !== 8'd0) begin n_fail++; $display("FAIL coords_after_rst: got (%0d,%0d) required (224,0)", bus.win_x, bus.win_y); end
        rd(2'd1, d); n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL irq_en_after_rst: got %h required 00", d); end
        rd(2'd2, d); n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL line_cmp_after_rst: got %h required 00", d); end
        rst = 1'b0;
        step(2);
        rd(2'd0, d); n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL status_after_rst: got %h required 00", d); end
        wait_pos(100, 10);
        n_tests++; if (bus.rgb !== 6'h3F) begin n_fail++; $display("FAIL drawing_pre_rst: got %h required 3f", bus.rgb); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.rgb !== 6'h00) begin n_fail++; $display("FAIL rgb_in_rst: got %h required 00", bus.rgb); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.rgb !== 6'h00) begin n_fail++; $display("FAIL no_stale_pixel: got %h required 00", bus.rgb); end
    endtask

    initial begin
        bus.reg_addr    = 2'd0;
        bus.reg_wdata   = 8'h00;
        bus.reg_we      = 1'b0;
        bus.reg_sel     = 1'b0;
        bus.layer_valid = 2'b11;
        bus.layer_rgb   = {6'h15, 6'h3F};
        test_reset();
        test_registers();
        test_frame();
        test_layers();
        test_window_edge();
        test_line_match();
        test_irq();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
